// File: rtl/comparator_search_ctrl.sv
// rtl/comparator_search_ctrl.sv - binary-search controller driving comparator operand b
// Probes a magnitude comparator until equality, reporting the value, probe count and flag errors.
module comparator_search_ctrl #(
    parameter int WIDTH = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    output logic [WIDTH-1:0] guess_o,
    input  logic             cmp_lt_i,
    input  logic             cmp_gt_i,
    input  logic             cmp_eq_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic [WIDTH:0]   probes_o,
    output logic             error_o
);

    localparam logic [WIDTH-1:0] MAX_VAL = '1;
    localparam logic [WIDTH:0]   ONE_X   = 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PROBE,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] guess_q, guess_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH:0]   probes_q, probes_d;
    logic             error_q, error_d;

    // Bounds are held one bit wider so a bad update shows up as lo > hi rather than wrapping.
    logic [WIDTH:0]   lo_ext, hi_ext, mid_sum;
    logic             narrow;

    always_comb begin
        state_d  = state_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        guess_d  = guess_q;
        result_d = result_q;
        probes_d = probes_q;
        error_d  = error_q;
        lo_ext   = {1'b0, lo_q};
        hi_ext   = {1'b0, hi_q};
        mid_sum  = '0;
        narrow   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    lo_d     = '0;
                    hi_d     = MAX_VAL;
                    mid_sum  = {1'b0, MAX_VAL};
                    guess_d  = mid_sum[WIDTH:1];
                    probes_d = '0;
                    error_d  = 1'b0;
                    state_d  = S_PROBE;
                end
            end
            S_PROBE: begin
                probes_d = probes_q + ONE_X;
                case ({cmp_lt_i, cmp_gt_i, cmp_eq_i})
                    3'b001: begin
                        result_d = guess_q;
                        state_d  = S_DONE;
                    end
                    3'b100: begin
                        if (guess_q == '0) begin
                            error_d = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            hi_ext = {1'b0, guess_q} - ONE_X;
                            narrow = 1'b1;
                        end
                    end
                    3'b010: begin
                        if (guess_q == MAX_VAL) begin
                            error_d = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            lo_ext = {1'b0, guess_q} + ONE_X;
                            narrow = 1'b1;
                        end
                    end
                    default: begin
                        error_d = 1'b1;
                        state_d = S_DONE;
                    end
                endcase

                if (narrow) begin
                    if (lo_ext > hi_ext) begin
                        error_d = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        lo_d    = lo_ext[WIDTH-1:0];
                        hi_d    = hi_ext[WIDTH-1:0];
                        mid_sum = lo_ext + hi_ext;
                        guess_d = mid_sum[WIDTH:1];
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            lo_q     <= '0;
            hi_q     <= '0;
            guess_q  <= '0;
            result_q <= '0;
            probes_q <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            guess_q  <= guess_d;
            result_q <= result_d;
            probes_q <= probes_d;
            error_q  <= error_d;
        end
    end

    assign guess_o  = guess_q;
    assign result_o = result_q;
    assign probes_o = probes_q;
    assign error_o  = error_q;
    assign busy_o   = (state_q == S_PROBE);
    assign done_o   = (state_q == S_DONE);

endmodule

// File: tb/tb_comparator_search_ctrl.sv
// tb/tb_comparator_search_ctrl.sv - directed scoreboard bench for comparator_search_ctrl
module tb_comparator_search_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [2:0] guess;
    logic       cmp_lt, cmp_gt, cmp_eq;
    logic       busy, done, error;
    logic [2:0] result;
    logic [3:0] probes;

    logic [2:0] a_val = 3'd0;
    int         mode = 0;
    logic [2:0] force_flags = 3'b000;

    typedef struct {
        int result;
        int probes;
        int err;
    } exp_t;

    exp_t sb[$];
    int   gq[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    comparator_search_ctrl #(.WIDTH(3)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .start_i  (start),
        .guess_o  (guess),
        .cmp_lt_i (cmp_lt),
        .cmp_gt_i (cmp_gt),
        .cmp_eq_i (cmp_eq),
        .busy_o   (busy),
        .done_o   (done),
        .result_o (result),
        .probes_o (probes),
        .error_o  (error)
    );

    // Mode 0 is an honest comparator, 1 forces a fixed pattern, 2 answers as if a were 4.5.
    always_comb begin
        case (mode)
            0:       {cmp_lt, cmp_gt, cmp_eq} = {a_val < guess, a_val > guess, a_val == guess};
            1:       {cmp_lt, cmp_gt, cmp_eq} = force_flags;
            default: {cmp_lt, cmp_gt, cmp_eq} = (guess <= 3'd4) ? 3'b010 : 3'b100;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input int res, input int pr, input int er);
        exp_t e;
        e.result = res;
        e.probes = pr;
        e.err    = er;
        sb.push_back(e);
    endtask

    task automatic model(input int a_v);
        int lo, hi, g, n;
        lo = 0;
        hi = 7;
        n  = 0;
        for (int k = 0; k < 8; k++) begin
            g = (lo + hi) / 2;
            gq.push_back(g);
            n++;
            if (g == a_v) break;
            if (a_v < g) hi = g - 1;
            else         lo = g + 1;
        end
        push_exp(a_v, n, 0);
    endtask

    task automatic run(input int a_v, input bit hold, input string tag);
        int   cyc;
        exp_t e;
        @(negedge clk);
        a_val = a_v[2:0];
        start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        cyc = 0;
        while (!done && cyc < 20) begin
            chk({tag, " busy"}, busy, 1);
            if (gq.size() > 0) chk({tag, " guess"}, guess, gq.pop_front());
            else               chk({tag, " unexpected extra probe"}, 1, 0);
            @(negedge clk);
            cyc++;
        end
        chk({tag, " done seen"}, done, 1);
        chk({tag, " guesses remaining"}, gq.size(), 0);
        gq.delete();
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, " result"}, result, e.result);
            chk({tag, " probes"}, probes, e.probes);
            chk({tag, " error"}, error, e.err);
        end else begin
            chk({tag, " scoreboard empty"}, 1, 0);
        end
        @(negedge clk);
        start = 1'b0;
        chk({tag, " done one cycle"}, done, 0);
        chk({tag, " idle after done"}, busy, 0);
    endtask

    initial begin
        int cyc;
        #1;
        chk("reset guess", guess, 0);
        chk("reset result", result, 0);
        chk("reset probes", probes, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset error", error, 0);
        @(negedge clk);
        rst = 1'b0;

        gq = '{3, 5};       push_exp(5, 2, 0); run(5, 0, "a5");
        gq = '{3, 5, 6, 7}; push_exp(7, 4, 0); run(7, 0, "a7");
        gq = '{3, 1, 0};    push_exp(0, 3, 0); run(0, 0, "a0");
        gq = '{3, 5, 4};    push_exp(4, 3, 0); run(4, 0, "a4");

        for (int v = 0; v < 8; v++) begin
            model(v);
            run(v, 1, $sformatf("sweep a%0d", v));
        end

        mode = 1;
        force_flags = 3'b000; gq = '{3};          push_exp(7, 1, 1); run(0, 0, "flags000");
        force_flags = 3'b010; gq = '{3, 5, 6, 7}; push_exp(7, 4, 1); run(0, 0, "gt at max");
        force_flags = 3'b100; gq = '{3, 1, 0};    push_exp(7, 3, 1); run(0, 0, "lt at zero");
        force_flags = 3'b110; gq = '{3};          push_exp(7, 1, 1); run(0, 0, "two-hot");
        mode = 2;
        gq = '{3, 5, 4}; push_exp(7, 3, 1); run(0, 0, "lo above hi");
        mode = 0;
        gq = '{3, 1, 2}; push_exp(2, 3, 0); run(2, 0, "after error");

        @(negedge clk);
        a_val = 3'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (guess !== 3'd5 && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        chk("mid-search reached guess 5", guess, 5);
        #2 rst = 1'b1;
        #1;
        chk("async rst guess", guess, 0);
        chk("async rst result", result, 0);
        chk("async rst probes", probes, 0);
        chk("async rst busy", busy, 0);
        chk("async rst done", done, 0);
        chk("async rst error", error, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle after rst", busy, 0);

        gq = '{3, 5, 6}; push_exp(6, 3, 0); run(6, 0, "fresh after rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
